// File: rtl/codec_ber_pkg.sv
// Shared types and default sizing for the codec bit-error-rate sequencer.
// Holds the sequencer state encoding and parameter defaults.
// No logic of its own.
package codec_ber_pkg;

    localparam int SAMPLE_W_DEF       = 24;
    localparam int CNT_W_DEF          = 16;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_FETCH    = 3'd2,
        ST_COMPRESS = 3'd3,
        ST_EXPAND   = 3'd4,
        ST_COMPARE  = 3'd5,
        ST_DONE     = 3'd6
    } seq_state_t;

    // A run is in progress anywhere between the counter clear and the compare strobe.
    function automatic logic is_busy(input seq_state_t s);
        return (s == ST_CLEAR) || (s == ST_FETCH) || (s == ST_COMPRESS) ||
               (s == ST_EXPAND) || (s == ST_COMPARE);
    endfunction

endpackage

// File: rtl/codec_ber_sequencer_watchdog.sv
// Cycle watchdog for a codec handshake: counts enabled cycles since the last clear.
// expired is combinational and rises on the TIMEOUT_CYCLES-th enabled cycle.
// No backpressure; the counter saturates while expired until the next clear.
module handshake_watchdog
    import codec_ber_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = enable && (cnt_q == LAST);

    // Restart on every state entry, otherwise count enabled cycles up to the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/codec_ber_sequencer.sv
// Sequences samples through an external compressor/expander pair and strobes an error counter.
// One sample per FETCH..COMPARE loop; latency set by the codec handshakes, bounded by the watchdog.
// Source is backpressured via sample_ready (FETCH only); abort overrides every handshake.
module codec_ber_sequencer
    import codec_ber_pkg::*;
#(
    parameter int SAMPLE_W       = SAMPLE_W_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    num_samples,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                sample_ready,
    output logic                comp_read,
    input  logic                comp_write,
    output logic                exp_read,
    input  logic                exp_write,
    input  logic [SAMPLE_W-1:0] exp_data,
    output logic [SAMPLE_W-1:0] comp_data,
    output logic [SAMPLE_W-1:0] test_pattern,
    output logic                cmp_reset,
    output logic                cmp_change,
    output logic                cmp_enable,
    input  logic                error_flag,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic                err_stop,
    output logic [CNT_W-1:0]    sample_count
);

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    count_inc;
    logic [SAMPLE_W-1:0] comp_data_q, comp_data_d;
    logic [SAMPLE_W-1:0] test_pattern_q, test_pattern_d;
    logic                timeout_q, timeout_d;
    logic                err_stop_q, err_stop_d;

    logic                wd_clear;
    logic                wd_enable;
    logic                wd_expired;

    assign count_inc = count_q + 1'b1;

    // The watchdog restarts whenever the state changes, so each handshake gets a fresh budget.
    assign wd_clear  = (state_d != state_q);
    assign wd_enable = (state_q == ST_COMPRESS) || (state_q == ST_EXPAND);

    handshake_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Next-state and datapath update; abort wins over every handshake, a write wins over the watchdog.
    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        count_d        = count_q;
        comp_data_d    = comp_data_q;
        test_pattern_d = test_pattern_q;
        timeout_d      = timeout_q;
        err_stop_d     = err_stop_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d      = num_samples;
                    count_d    = '0;
                    timeout_d  = 1'b0;
                    err_stop_d = 1'b0;
                    state_d    = (num_samples == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = abort ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (sample_valid) begin
                    comp_data_d = sample_in;
                    state_d     = ST_COMPRESS;
                end
            end
            ST_COMPRESS: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (comp_write) begin
                    state_d = ST_EXPAND;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_EXPAND: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (exp_write) begin
                    test_pattern_d = exp_data;
                    state_d        = ST_COMPARE;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_COMPARE: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_inc;
                    if ((count_inc == num_q) || error_flag) begin
                        err_stop_d = error_flag;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the current state; the ones abort can cancel are gated by it.
    always_comb begin
        sample_ready = (state_q == ST_FETCH) && !abort;
        comp_read    = (state_q == ST_COMPRESS);
        exp_read     = (state_q == ST_EXPAND);
        cmp_reset    = (state_q == ST_CLEAR);
        cmp_change   = (state_q == ST_COMPARE) && !abort;
        busy         = is_busy(state_q);
        cmp_enable   = is_busy(state_q);
        done         = (state_q == ST_DONE);
    end

    assign comp_data    = comp_data_q;
    assign test_pattern = test_pattern_q;
    assign timeout      = timeout_q;
    assign err_stop     = err_stop_q;
    assign sample_count = count_q;

    // State and datapath registers, async active-low reset back to an empty IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            num_q          <= '0;
            count_q        <= '0;
            comp_data_q    <= '0;
            test_pattern_q <= '0;
            timeout_q      <= 1'b0;
            err_stop_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            count_q        <= count_d;
            comp_data_q    <= comp_data_d;
            test_pattern_q <= test_pattern_d;
            timeout_q      <= timeout_d;
            err_stop_q     <= err_stop_d;
        end
    end

endmodule

// File: tb/tb_codec_ber_sequencer.sv
// Self-checking bench: codec/source responders plus a run-level reference model.
module tb_codec_ber_sequencer;

    localparam int SW = 24;
    localparam int CW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_samples = '0;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] sample_in = '0;
    logic          sample_ready;
    logic          comp_read;
    logic          comp_write = 1'b0;
    logic          exp_read;
    logic          exp_write = 1'b0;
    logic [SW-1:0] exp_data = '0;
    logic [SW-1:0] comp_data;
    logic [SW-1:0] test_pattern;
    logic          cmp_reset;
    logic          cmp_change;
    logic          cmp_enable;
    logic          error_flag = 1'b0;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          err_stop;
    logic [CW-1:0] sample_count;

    codec_ber_sequencer #(
        .SAMPLE_W       (SW),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .num_samples  (num_samples),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .comp_read    (comp_read),
        .comp_write   (comp_write),
        .exp_read     (exp_read),
        .exp_write    (exp_write),
        .exp_data     (exp_data),
        .comp_data    (comp_data),
        .test_pattern (test_pattern),
        .cmp_reset    (cmp_reset),
        .cmp_change   (cmp_change),
        .cmp_enable   (cmp_enable),
        .error_flag   (error_flag),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .err_stop     (err_stop),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Scenario knobs read by the responder.
    int comp_lat  = 2;
    int exp_lat   = 2;
    bit comp_hang = 1'b0;
    int err_at    = 0;
    int abort_at  = 0;

    // Observations gathered by the monitor.
    int            cyc = 0;
    int            n_change_run = 0;
    int            n_reset = 0;
    int            n_comp_cyc = 0;
    int            abort_cyc = -1;
    int            done_cyc = -1;
    int            comp_cnt = 0;
    int            exp_cnt = 0;
    logic [SW-1:0] cur_sample = '0;
    logic [SW-1:0] src_q[$];
    logic [SW-1:0] ref_q[$];
    logic [SW-1:0] obs_a[$];
    logic [SW-1:0] obs_b[$];

    logic [SW-1:0] fixed_smp [3] = '{24'hE38E38, 24'h43AE2C, 24'd4};

    // Lossy codec behaviour: the low byte does not survive the round trip.
    function automatic logic [SW-1:0] codec_model(input logic [SW-1:0] x);
        return x & {{(SW-8){1'b1}}, 8'h00};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Responder drives source/codec/abort/error inputs at negedge+1, then monitors at negedge+2.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        abort      = 1'b0;
        error_flag = 1'b0;
        if (!reset) begin
            sample_valid = 1'b0;
            comp_write   = 1'b0;
            exp_write    = 1'b0;
            comp_cnt     = 0;
            exp_cnt      = 0;
        end else begin
            if (abort_at > 0 && exp_read && n_change_run == abort_at - 1) begin
                abort     = 1'b1;
                abort_cyc = cyc;
            end
            if (comp_read) begin
                comp_cnt++;
                comp_write = !comp_hang && (comp_cnt > comp_lat);
            end else begin
                comp_cnt   = 0;
                comp_write = 1'b0;
            end
            if (exp_read) begin
                exp_cnt++;
                exp_write = (exp_cnt > exp_lat);
            end else begin
                exp_cnt   = 0;
                exp_write = 1'b0;
            end
            exp_data     = exp_write ? codec_model(cur_sample) : SW'($urandom);
            sample_valid = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
            sample_in    = (src_q.size() > 0) ? src_q[0] : SW'($urandom);
            error_flag   = (err_at > 0) && cmp_change && (n_change_run + 1 == err_at);
        end
        #1;
        if (reset) begin
            if (sample_valid && sample_ready) begin
                cur_sample = sample_in;
                void'(src_q.pop_front());
            end
            if (cmp_reset) n_reset++;
            if (comp_read) n_comp_cyc++;
            if (cmp_change) begin
                obs_a.push_back(comp_data);
                obs_b.push_back(test_pattern);
                n_change_run++;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
        end
    end

    // One complete run followed by a check of its outcome against the run-level model.
    task automatic run_test(input string tag, input int n, input int e_at, input int a_at,
                            input bit hang, input bit fixed);
        int            k;
        int            start_cyc;
        logic [SW-1:0] s;
        src_q.delete();
        ref_q.delete();
        obs_a.delete();
        obs_b.delete();
        for (int i = 0; i < n; i++) begin
            s = (fixed && i < 3) ? fixed_smp[i] : SW'($urandom);
            src_q.push_back(s);
            ref_q.push_back(s);
        end
        @(negedge clk);
        err_at       = e_at;
        abort_at     = a_at;
        comp_hang    = hang;
        n_change_run = 0;
        n_reset      = 0;
        n_comp_cyc   = 0;
        abort_cyc    = -1;
        num_samples  = CW'(n);
        start        = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc + 1;
        done_cyc  = -1;
        for (int c = 0; c < 4000 && !done; c++) @(negedge clk);
        #3;
        check({tag, " done"}, 64'(done), 64'd1);

        // Expected number of compares: stops at the count, the failing compare, or before the aborted one.
        k = n;
        if (e_at > 0 && e_at < k) k = e_at;
        if (a_at > 0 && a_at - 1 < k) k = a_at - 1;
        if (hang) k = 0;

        check({tag, " cmp_change pulses"}, 64'(n_change_run), 64'(k));
        for (int i = 0; i < k; i++) begin
            if (i < obs_a.size()) begin
                check($sformatf("%s pattern1[%0d]", tag, i), 64'(obs_a[i]), 64'(ref_q[i]));
                check($sformatf("%s pattern2[%0d]", tag, i), 64'(obs_b[i]), 64'(codec_model(ref_q[i])));
            end
        end
        check({tag, " sample_count"}, 64'(sample_count), 64'(k));
        check({tag, " err_stop"}, 64'(err_stop), 64'((e_at > 0 && k == e_at) ? 1 : 0));
        check({tag, " timeout"}, 64'(timeout), 64'(hang));
        check({tag, " cmp_reset pulses"}, 64'(n_reset), 64'((n > 0) ? 1 : 0));
        check({tag, " busy"}, 64'(busy), 64'd0);
        if (hang) check({tag, " compress cycles"}, 64'(n_comp_cyc), 64'(TO));
        if (a_at > 0) check({tag, " abort->done"}, 64'(done_cyc), 64'(abort_cyc + 1));
        if (n == 0) check({tag, " zero->done"}, 64'(done_cyc), 64'(start_cyc));
    endtask

    initial begin
        int n;
        int e;
        #2;
        check("reset flags", 64'({sample_ready, comp_read, exp_read, cmp_reset, cmp_change,
                                  cmp_enable, busy, done, timeout, err_stop}), 64'd0);
        check("reset count", 64'(sample_count), 64'd0);
        check("reset data", 64'({comp_data, test_pattern}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        comp_lat = 2;
        exp_lat  = 2;
        run_test("three", 3, 0, 0, 1'b0, 1'b1);
        run_test("zero", 0, 0, 0, 1'b0, 1'b0);
        run_test("hang", 2, 0, 0, 1'b1, 1'b0);
        comp_lat = 1;
        exp_lat  = 0;
        run_test("errstop", 10, 4, 0, 1'b0, 1'b0);
        comp_lat = 0;
        exp_lat  = 3;
        run_test("abort", 3, 0, 2, 1'b0, 1'b0);

        // Asynchronous reset while the compressor is stalled.
        src_q.delete();
        src_q.push_back(24'hA5A5A5);
        comp_hang = 1'b1;
        err_at    = 0;
        abort_at  = 0;
        @(negedge clk);
        num_samples = 16'd4;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && !comp_read; c++) @(negedge clk);
        check("reach compress", 64'(comp_read), 64'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("async reset flags", 64'({sample_ready, comp_read, exp_read, cmp_reset, cmp_change,
                                        cmp_enable, busy, done, timeout, err_stop}), 64'd0);
        check("async reset data", 64'({comp_data, test_pattern}), 64'd0);
        @(negedge clk);
        reset     = 1'b1;
        comp_hang = 1'b0;
        comp_lat  = 2;
        exp_lat   = 1;
        run_test("after reset", 3, 0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n        = $urandom_range(1, 6);
            e        = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            comp_lat = $urandom_range(0, 3);
            exp_lat  = $urandom_range(0, 3);
            run_test($sformatf("rand%0d", r), n, e, 0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout: observed time limit reached, expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
